// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//   Brings up a PLL and gates the downstream system reset on a stable lock.
//   Each attempt holds the PLL in reset for PLL_RST_CYCLES, then waits up to
//   LOCK_TIMEOUT cycles for LOCK_STABLE_CYCLES consecutive locked cycles.
//   Failed attempts are counted; MAX_RETRIES failures park the block in FAULT
//   until a restart pulse. A lock drop while running restarts the sequence
//   and raises a sticky lock_lost flag.
//
// Ports
//   clk           free-running reference clock (also the PLL input clock)
//   reset_n       asynchronous active-low reset
//   locked_in     PLL lock indicator, asynchronous to clk
//   restart       single-cycle pulse, leaves FAULT
//   clear_status  single-cycle pulse, clears lock_lost
//   pll_rst       active-high reset to the PLL
//   sys_reset_n   active-low reset for downstream logic
//   lock_lost     sticky: lock dropped while running
//   fault         high while in FAULT
//   retry_count   failed attempts since the last RUN entry or restart
//   state         0=PLL_RESET 1=WAIT_LOCK 2=RUN 3=FAULT
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
  parameter int unsigned PLL_RST_CYCLES     = 32'd16,
  parameter int unsigned LOCK_STABLE_CYCLES = 32'd1024,
  parameter int unsigned LOCK_TIMEOUT       = 32'd65536,
  parameter int unsigned MAX_RETRIES        = 32'd7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       locked_in,
  input  logic       restart,
  input  logic       clear_status,
  output logic       pll_rst,
  output logic       sys_reset_n,
  output logic       lock_lost,
  output logic       fault,
  output logic [3:0] retry_count,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_PLL_RESET = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  localparam int unsigned RST_W = $clog2(PLL_RST_CYCLES + 32'd1);
  localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 32'd1);
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT + 32'd1);

  localparam logic [RST_W-1:0] RST_LAST   = RST_W'(PLL_RST_CYCLES - 32'd1);
  localparam logic [RST_W-1:0] RST_ONE    = RST_W'(32'd1);
  localparam logic [STB_W-1:0] STB_TARGET = STB_W'(LOCK_STABLE_CYCLES);
  localparam logic [STB_W-1:0] STB_ONE    = STB_W'(32'd1);
  localparam logic [TMO_W-1:0] TMO_TARGET = TMO_W'(LOCK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_ONE    = TMO_W'(32'd1);
  localparam logic [3:0]       RETRY_MAX  = 4'(MAX_RETRIES);

  logic             sync_r;
  logic             locked_s;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [RST_W-1:0] rst_cnt_r;
  logic [RST_W-1:0] rst_cnt_nxt_s;
  logic [RST_W-1:0] rst_inc_s;
  logic [STB_W-1:0] stable_cnt_r;
  logic [STB_W-1:0] stable_cnt_nxt_s;
  logic [STB_W-1:0] stable_inc_s;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_nxt_s;
  logic [TMO_W-1:0] tmo_inc_s;
  logic [3:0]       retry_nxt_s;
  logic [3:0]       retry_inc_s;
  logic             lost_set_s;
  logic             lock_lost_nxt_s;

  assign state = state_r;

  // Saturating increments: counters hold at their terminal value, never wrap.
  assign rst_inc_s    = (rst_cnt_r >= RST_LAST) ? RST_LAST : rst_cnt_r + RST_ONE;
  assign stable_inc_s = (stable_cnt_r >= STB_TARGET) ? STB_TARGET : stable_cnt_r + STB_ONE;
  assign tmo_inc_s    = (tmo_cnt_r >= TMO_TARGET) ? TMO_TARGET : tmo_cnt_r + TMO_ONE;
  assign retry_inc_s  = (retry_count >= RETRY_MAX) ? RETRY_MAX : retry_count + 4'd1;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_r   <= locked_in;
      locked_s <= sync_r;
    end
  end

  // Next-state and next-counter logic of the lock sequencer.
  always_comb begin
    state_nxt_s      = state_r;
    rst_cnt_nxt_s    = rst_cnt_r;
    stable_cnt_nxt_s = stable_cnt_r;
    tmo_cnt_nxt_s    = tmo_cnt_r;
    retry_nxt_s      = retry_count;
    lost_set_s       = 1'b0;
    case (state_r)
      ST_PLL_RESET: begin
        if (rst_cnt_r >= RST_LAST) begin
          state_nxt_s      = ST_WAIT_LOCK;
          rst_cnt_nxt_s    = {RST_W{1'b0}};
          stable_cnt_nxt_s = {STB_W{1'b0}};
          tmo_cnt_nxt_s    = {TMO_W{1'b0}};
        end else begin
          rst_cnt_nxt_s = rst_inc_s;
        end
      end
      ST_WAIT_LOCK: begin
        // Stability is tested before the timeout so that a tie enters RUN.
        if (locked_s && (stable_inc_s == STB_TARGET)) begin
          state_nxt_s      = ST_RUN;
          retry_nxt_s      = 4'd0;
          stable_cnt_nxt_s = {STB_W{1'b0}};
          tmo_cnt_nxt_s    = {TMO_W{1'b0}};
        end else if (tmo_inc_s == TMO_TARGET) begin
          retry_nxt_s      = retry_inc_s;
          rst_cnt_nxt_s    = {RST_W{1'b0}};
          stable_cnt_nxt_s = {STB_W{1'b0}};
          tmo_cnt_nxt_s    = {TMO_W{1'b0}};
          if (retry_inc_s == RETRY_MAX) begin
            state_nxt_s = ST_FAULT;
          end else begin
            state_nxt_s = ST_PLL_RESET;
          end
        end else begin
          tmo_cnt_nxt_s = tmo_inc_s;
          if (locked_s) begin
            stable_cnt_nxt_s = stable_inc_s;
          end else begin
            stable_cnt_nxt_s = {STB_W{1'b0}};
          end
        end
      end
      ST_RUN: begin
        // A lock drop restarts the sequence without charging a retry.
        if (!locked_s) begin
          state_nxt_s   = ST_PLL_RESET;
          rst_cnt_nxt_s = {RST_W{1'b0}};
          lost_set_s    = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (restart) begin
          state_nxt_s   = ST_PLL_RESET;
          rst_cnt_nxt_s = {RST_W{1'b0}};
          retry_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ST_FAULT;
        end
      end
      default: begin
        state_nxt_s   = ST_PLL_RESET;
        rst_cnt_nxt_s = {RST_W{1'b0}};
      end
    endcase

    // A same-cycle loss outranks a clear request.
    if (lost_set_s) begin
      lock_lost_nxt_s = 1'b1;
    end else if (clear_status) begin
      lock_lost_nxt_s = 1'b0;
    end else begin
      lock_lost_nxt_s = lock_lost;
    end
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they line up with the state register in every cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_PLL_RESET;
      rst_cnt_r    <= {RST_W{1'b0}};
      stable_cnt_r <= {STB_W{1'b0}};
      tmo_cnt_r    <= {TMO_W{1'b0}};
      retry_count  <= 4'd0;
      lock_lost    <= 1'b0;
      fault        <= 1'b0;
      pll_rst      <= 1'b1;
      sys_reset_n  <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      rst_cnt_r    <= rst_cnt_nxt_s;
      stable_cnt_r <= stable_cnt_nxt_s;
      tmo_cnt_r    <= tmo_cnt_nxt_s;
      retry_count  <= retry_nxt_s;
      lock_lost    <= lock_lost_nxt_s;
      fault        <= (state_nxt_s == ST_FAULT);
      pll_rst      <= (state_nxt_s == ST_PLL_RESET) || (state_nxt_s == ST_FAULT);
      sys_reset_n  <= (state_nxt_s == ST_RUN);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Directed scenarios (clean lock, loss in RUN, glitch, async reset, retries
//   to FAULT, stable/timeout tie) followed by randomized lock activity. Every
//   cycle the outputs are compared with a behavioural model that tracks the
//   phase, time spent in it, the current lock streak and the retry tally.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

  localparam int P = 4;
  localparam int L = 8;
  localparam int T = 32;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked_in;
  logic       restart;
  logic       clear_status;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       lock_lost;
  logic       fault;
  logic [3:0] retry_count;
  logic [1:0] state;

  int checks   = 0;
  int failures = 0;
  int n;
  int flip_div;

  // Model: phase 0..3, cycles spent in phase, consecutive locked_s count,
  // retry tally, sticky flag, and the two synchronizer stages.
  int m_phase;
  int m_elapsed;
  int m_streak;
  int m_retry;
  bit m_lost;
  bit m_s1;
  bit m_s2;

  pll_lock_sequencer #(
    .PLL_RST_CYCLES(P),
    .LOCK_STABLE_CYCLES(L),
    .LOCK_TIMEOUT(T),
    .MAX_RETRIES(R)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .locked_in(locked_in),
    .restart(restart),
    .clear_status(clear_status),
    .pll_rst(pll_rst),
    .sys_reset_n(sys_reset_n),
    .lock_lost(lock_lost),
    .fault(fault),
    .retry_count(retry_count),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_streak  = 0;
    m_retry   = 0;
    m_lost    = 1'b0;
    m_s1      = 1'b0;
    m_s2      = 1'b0;
  endfunction

  function automatic void model_step();
    bit ls;
    bit set_lost;
    set_lost = 1'b0;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = locked_in;
    case (m_phase)
      0: begin
        m_elapsed++;
        if (m_elapsed == P) begin
          m_phase   = 1;
          m_elapsed = 0;
          m_streak  = 0;
        end
      end
      1: begin
        m_elapsed++;
        m_streak = ls ? m_streak + 1 : 0;
        if (m_streak == L) begin
          m_phase = 2;
          m_retry = 0;
        end else if (m_elapsed == T) begin
          m_retry   = (m_retry < R) ? m_retry + 1 : R;
          m_phase   = (m_retry == R) ? 3 : 0;
          m_elapsed = 0;
        end
      end
      2: begin
        if (!ls) begin
          m_phase   = 0;
          m_elapsed = 0;
          set_lost  = 1'b1;
        end
      end
      3: begin
        if (restart) begin
          m_phase   = 0;
          m_retry   = 0;
          m_elapsed = 0;
        end
      end
      default: m_phase = 0;
    endcase
    if (set_lost) m_lost = 1'b1;
    else if (clear_status) m_lost = 1'b0;
  endfunction

  task automatic compare_all();
    check("state", 32'(state), 32'(m_phase));
    check("pll_rst", 32'(pll_rst), 32'((m_phase == 0) || (m_phase == 3)));
    check("sys_reset_n", 32'(sys_reset_n), 32'(m_phase == 2));
    check("fault", 32'(fault), 32'(m_phase == 3));
    check("retry_count", 32'(retry_count), 32'(m_retry));
    check("lock_lost", 32'(lock_lost), 32'(m_lost));
  endtask

  // One clock: the model advances on the edge, outputs are compared at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  // Asserts reset between edges, checks the reset values with no clock edge,
  // holds it across one edge, then releases at a negedge.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pll_rst", 32'(pll_rst), 32'd1);
    check("rst_sys_reset_n", 32'(sys_reset_n), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_retry", 32'(retry_count), 32'd0);
    @(negedge clk);
    check("rst_hold_state", 32'(state), 32'd0);
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b1;
    locked_in    = 1'b0;
    restart      = 1'b0;
    clear_status = 1'b0;
    #1;

    // Clean lock from the first cycle after reset.
    locked_in = 1'b1;
    apply_reset();
    n = 0;
    do begin tick(); n++; end while (pll_rst !== 1'b0 && n < 50);
    check("pll_rst_len", 32'(n), 32'(P));
    do begin tick(); n++; end while (sys_reset_n !== 1'b1 && n < 100);
    check("lock_time", 32'(n), 32'(P + L));
    check("run_state", 32'(state), 32'd2);

    // Lock loss in RUN with clear_status in the same cycle as the loss.
    repeat (3) tick();
    locked_in = 1'b0;
    tick();
    tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("loss_lock_lost", 32'(lock_lost), 32'd1);
    check("loss_state", 32'(state), 32'd0);
    check("loss_sys_reset_n", 32'(sys_reset_n), 32'd0);
    check("loss_retry", 32'(retry_count), 32'd0);
    tick();
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check("clear_lock_lost", 32'(lock_lost), 32'd0);

    // Glitch: six locked cycles in WAIT_LOCK, one low, then stable.
    locked_in = 1'b1;
    apply_reset();
    repeat (8) tick();
    locked_in = 1'b0;
    tick();
    locked_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (sys_reset_n !== 1'b1 && n < 50);
    check("glitch_release", 32'(n), 32'd10);

    // Asynchronous reset in the middle of RUN, then no lock ever.
    tick();
    tick();
    locked_in = 1'b0;
    apply_reset();
    n = 0;
    do begin
      restart = (n == 20);
      tick();
      n++;
    end while (fault !== 1'b1 && n < 200);
    restart = 1'b0;
    check("fault_time", 32'(n), 32'(2 * (P + T)));
    check("fault_state", 32'(state), 32'd3);
    check("fault_pll_rst", 32'(pll_rst), 32'd1);
    check("fault_retry", 32'(retry_count), 32'(R));
    repeat (3) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("restart_state", 32'(state), 32'd0);
    check("restart_retry", 32'(retry_count), 32'd0);
    check("restart_fault", 32'(fault), 32'd0);

    // Tie: second attempt reaches stability in its 32nd WAIT_LOCK cycle.
    locked_in = 1'b0;
    apply_reset();
    repeat (62) tick();
    locked_in = 1'b1;
    n = 62;
    do begin tick(); n++; end while (sys_reset_n !== 1'b1 && n < 120);
    check("tie_time", 32'(n), 32'(2 * P + 2 * T));
    check("tie_state", 32'(state), 32'd2);
    check("tie_fault", 32'(fault), 32'd0);

    // Randomized lock activity with stray restart and clear pulses.
    flip_div = 8;
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) flip_div = $urandom_range(60, 3);
      if ($urandom_range(flip_div - 1, 0) == 0) locked_in = ~locked_in;
      restart      = ($urandom_range(19, 0) == 0);
      clear_status = ($urandom_range(9, 0) == 0);
      tick();
    end
    restart      = 1'b0;
    clear_status = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
